ps2_keyboard_rx: RTL and testbench

//  Receives PS/2 keyboard frames, decodes scan-code sequences (make/break/extended/shift) and

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_scancode_lut.sv | 38 +++
 rtl/ps2_keyboard_rx.sv | 172 +++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_scancode_lut.sv
// Set-2 scan code to ASCII: letters, digits, space, enter, backspace; unmapped codes give 0.
module ps2_scancode_lut (
  input  logic       shift_i,
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o
);

  logic [7:0] base;

  always_comb begin
    base = 8'h00;
    case (code_i)
      8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;  8'h23: base = 8'h64;
      8'h24: base = 8'h65;  8'h2B: base = 8'h66;  8'h34: base = 8'h67;  8'h33: base = 8'h68;
      8'h43: base = 8'h69;  8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
      8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;  8'h4D: base = 8'h70;
      8'h15: base = 8'h71;  8'h2D: base = 8'h72;  8'h1B: base = 8'h73;  8'h2C: base = 8'h74;
      8'h3C: base = 8'h75;  8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
      8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
      8'h45: base = 8'h30;  8'h16: base = 8'h31;  8'h1E: base = 8'h32;  8'h26: base = 8'h33;
      8'h25: base = 8'h34;  8'h2E: base = 8'h35;  8'h36: base = 8'h36;  8'h3D: base = 8'h37;
      8'h3E: base = 8'h38;  8'h46: base = 8'h39;
      8'h29: base = 8'h20;
      8'h5A: base = 8'h0D;
      8'h66: base = 8'h08;
      default: base = 8'h00;
    endcase
  end

  // Shift only changes letter case; digits and control keys pass through.
  always_comb begin
    ascii_o = base;
    if (shift_i && (base >= 8'h61) && (base <= 8'h7A)) begin
      ascii_o = base - 8'h20;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, frames bytes, decodes
// make/break/extended/shift sequences and writes one ASCII byte per key press to the FIFO.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       fifo_full,
  output logic [7:0] char,
  output logic       wrreq,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN) + 1;
  localparam int unsigned TimeW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             filt_clk_q, filt_clk_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic [TimeW-1:0] to_cnt_q, to_cnt_d;
  rx_state_t        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             code_valid_q, code_valid_d;
  logic             brk_q, brk_d, ext_q, ext_d, shift_q, shift_d;
  logic [7:0]       char_q, char_d;
  logic             wrreq_q, wrreq_d, frame_err_q, frame_err_d, overflow_q, overflow_d;
  logic             fall_tick, timeout, data_bit, fire;
  logic [7:0]       lut_ascii;

  assign data_bit = data_sync_q[1];

  // The filtered clock follows the input only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall_tick = filt_clk_q & ~filt_clk_d;
  assign timeout   = (state_q != IDLE) && (to_cnt_q == TimeW'(TIMEOUT_CYCLES - 1));
  assign to_cnt_d  = (fall_tick || timeout || (state_q == IDLE)) ? '0 : to_cnt_q + 1'b1;

  // Timeout has priority over a coincident fall_tick.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (timeout) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      frame_err_d = 1'b1;
    end else if (fall_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!data_bit) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shreg_d   = {data_bit, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_bit;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_bit && (^{shreg_q, par_q})) code_valid_d = 1'b1;
          else frame_err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  ps2_scancode_lut u_lut (
    .shift_i (shift_q),
    .code_i  (shreg_q),
    .ascii_o (lut_ascii)
  );

  // shreg_q still holds the completed byte in the cycle code_valid_q is high.
  always_comb begin
    brk_d   = brk_q;
    ext_d   = ext_q;
    shift_d = shift_q;
    fire    = 1'b0;
    if (code_valid_q) begin
      if (shreg_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (shreg_q == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        if (is_shift_code(shreg_q)) shift_d = ~brk_q;
        else if (!brk_q && !ext_q && (lut_ascii != 8'h00)) fire = 1'b1;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
    wrreq_d    = fire & ~fifo_full;
    overflow_d = fire & fifo_full;
    char_d     = wrreq_d ? lut_ascii : char_q;
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      filt_clk_q   <= 1'b1;
      filt_cnt_q   <= '0;
      to_cnt_q     <= '0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      code_valid_q <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      shift_q      <= 1'b0;
      char_q       <= '0;
      wrreq_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk};
      data_sync_q  <= {data_sync_q[0], ps2_data};
      filt_clk_q   <= filt_clk_d;
      filt_cnt_q   <= filt_cnt_d;
      to_cnt_q     <= to_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      code_valid_q <= code_valid_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      shift_q      <= shift_d;
      char_q       <= char_d;
      wrreq_q      <= wrreq_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign char      = char_q;
  assign wrreq     = wrreq_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed and randomised keystroke bench for ps2_keyboard_rx with a keystroke-level model.
module tb_ps2_keyboard_rx;

  localparam int unsigned FilterLen     = 8;
  localparam int unsigned TimeoutCycles = 2000;
  localparam int          SetupCyc      = 6;
  localparam int          LowCyc        = 12;
  localparam int          HoldCyc       = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       fifo_full = 1'b0;
  logic [7:0] char;
  logic       wrreq, frame_err, overflow;

  always #10 clk = ~clk;

  ps2_keyboard_rx #(
    .FILTER_LEN     (FilterLen),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk_50MHz (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fifo_full (fifo_full),
    .char      (char),
    .wrreq     (wrreq),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  // Set-2 codes for a..z then 0..9; ASCII follows from the index.
  logic [7:0] key_code [36] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
    8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
    8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] ext_code [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         ferr_cnt = 0;
  int         ovf_cnt = 0;
  int         consec = 0;
  int         wr_cyc = 0;
  int         stop_cyc = 0;
  logic       prev_wr = 1'b0;
  logic [7:0] got [$];
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wrreq === 1'b1) begin
      got.push_back(char);
      wr_cyc = cyc;
      if (prev_wr) consec++;
    end
    prev_wr = (wrreq === 1'b1);
    if (frame_err === 1'b1) ferr_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic bad_par);
    return {1'b1, (~^code) ^ bad_par, code, 1'b0};
  endfunction

  function automatic logic [7:0] model_ascii(input int idx, input logic shifted);
    if (idx < 26) return shifted ? 8'(8'h41 + idx) : 8'(8'h61 + idx);
    return 8'(8'h30 + idx - 26);
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      if (i == glitch_at) begin
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FilterLen - 3) @(negedge clk);
        ps2_clk = 1'b1;
      end
      repeat (SetupCyc) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (LowCyc) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HoldCyc) @(negedge clk);
    end
  endtask

  task automatic send_code(input logic [7:0] code);
    send_bits(mk_frame(code, 1'b0), 11, -1);
  endtask

  task automatic press_key(input logic [7:0] code, input logic shifted, input logic rshift);
    logic [7:0] sc;
    sc = rshift ? 8'h59 : 8'h12;
    if (shifted) send_code(sc);
    send_code(code);
    send_code(8'hF0);
    send_code(code);
    if (shifted) begin
      send_code(8'hF0);
      send_code(sc);
    end
  endtask

  initial begin
    int f0, o0, lat, idx, r;
    logic sh, rs;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wrreq", wrreq, 0);
    check("rst_char", char, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single make/break of 'a', with latency from the stop-bit edge
    got.delete(); f0 = ferr_cnt;
    send_code(8'h1C);
    lat = wr_cyc - stop_cyc;
    send_code(8'hF0); send_code(8'h1C);
    check("t1_count", got.size(), 1);
    check("t1_char", got_at(0), 8'h61);
    check("t1_latency_window", (lat >= int'(FilterLen) + 1) && (lat <= int'(FilterLen) + 6), 1);
    check("t1_no_err", ferr_cnt - f0, 0);
    check("t1_char_held", char, 8'h61);
    check("t1_wrreq_idle", wrreq, 0);

    // 2: shifted 'A', then shift released
    got.delete();
    press_key(8'h1C, 1'b1, 1'b0);
    check("t2_count", got.size(), 1);
    check("t2_char", got_at(0), 8'h41);
    got.delete();
    send_code(8'h1C);
    check("t2_unshift_char", got_at(0), 8'h61);

    // 3: bad parity, then good 'b'
    got.delete(); f0 = ferr_cnt;
    send_bits(mk_frame(8'h1C, 1'b1), 11, -1);
    repeat (4) @(negedge clk);
    check("t3_err", ferr_cnt - f0, 1);
    check("t3_no_wr", got.size(), 0);
    send_code(8'h32);
    check("t3_char", got_at(0), 8'h62);

    // Start bit sampled high
    f0 = ferr_cnt; got.delete();
    send_bits(11'h7FF, 1, -1);
    check("bad_start_err", ferr_cnt - f0, 1);
    send_code(8'h2B);
    check("bad_start_recover", got_at(0), 8'h66);

    // 4: truncated frame then timeout
    got.delete(); f0 = ferr_cnt;
    send_bits(mk_frame(8'h45, 1'b0), 5, -1);
    repeat (TimeoutCycles + 100) @(negedge clk);
    check("t4_timeout_err", ferr_cnt - f0, 1);
    check("t4_no_wr", got.size(), 0);
    send_code(8'h45);
    check("t4_char", got_at(0), 8'h30);
    check("t4_no_extra_err", ferr_cnt - f0, 1);

    // 5: FIFO full drops the character
    got.delete(); o0 = ovf_cnt;
    fifo_full = 1'b1;
    send_code(8'h1C);
    check("t5_overflow", ovf_cnt - o0, 1);
    check("t5_no_wr", got.size(), 0);
    fifo_full = 1'b0;
    send_code(8'hF0); send_code(8'h1C);
    send_code(8'h1C);
    check("t5_char", got_at(0), 8'h61);

    // 6: reset mid-frame with shift held; flags must be lost
    send_code(8'h12);
    send_bits(mk_frame(8'h1C, 1'b0), 4, -1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_wrreq", wrreq, 0);
    check("t6_rst_char", char, 0);
    check("t6_rst_err", frame_err, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    got.delete();
    send_code(8'h5A);
    check("t6_count", got.size(), 1);
    check("t6_char", got_at(0), 8'h0D);
    send_code(8'hF0); send_code(8'h5A);
    send_code(8'h1C);
    check("t6_shift_lost", got_at(1), 8'h61);

    // 7: short glitch on ps2_clk mid-frame
    got.delete(); f0 = ferr_cnt;
    send_bits(mk_frame(8'h4D, 1'b0), 11, 4);
    check("t7_char", got_at(0), 8'h70);
    check("t7_no_err", ferr_cnt - f0, 0);

    // Randomised keystrokes against the keystroke-level model
    got.delete(); exp_q.delete(); f0 = ferr_cnt;
    send_code(8'hF0); send_code(8'h4D);
    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        idx = $urandom_range(0, 3);
        send_code(8'hE0); send_code(ext_code[idx]);
        send_code(8'hE0); send_code(8'hF0); send_code(ext_code[idx]);
      end else begin
        idx = $urandom_range(0, 35);
        sh  = 1'($urandom_range(0, 1));
        rs  = 1'($urandom_range(0, 1));
        press_key(key_code[idx], sh, rs);
        exp_q.push_back(model_ascii(idx, sh));
      end
    end
    check("rand_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rand_char_%0d", i), got_at(i), exp_q[i]);
    end
    check("rand_no_err", ferr_cnt - f0, 0);
    check("no_back_to_back_wrreq", consec, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
